// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU issue sequencer: default geometry, opcode
// encodings, ALU select codes, FSM state type and small opcode decoders.
//
// Configuration macro: ALU_SUB_EN
//   defined   -> opcode 101 is SUB (two ALU passes via ST_NEG_B)
//   undefined -> ST_NEG_B does not exist and opcode 101 is illegal
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 12;
  localparam int SEQ_NREGS  = 8;
  localparam int SEQ_RA_W   = 3;

  // Instruction opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NEG  = 3'b010;
  localparam logic [2:0] OP_TSTN = 3'b011;
  localparam logic [2:0] OP_TSTZ = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  // ALU select codes
  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_AND  = 3'd1;
  localparam logic [2:0] SEL_NEG  = 3'd4;
  localparam logic [2:0] SEL_TSTN = 3'd5;
  localparam logic [2:0] SEL_TSTZ = 3'd6;
  localparam logic [2:0] SEL_IDLE = 3'd7;  // ALU drives all-zero outputs

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
`ifdef ALU_SUB_EN
    ST_WB    = 3'd3,
    ST_NEG_B = 3'd4
`else
    ST_WB    = 3'd3
`endif
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_SUB_EN
    return (op <= OP_SUB);
`else
    return (op <= OP_TSTZ);
`endif
  endfunction

  // Select used for the final (EXEC) pass. SUB finishes as ra + (-rb).
  function automatic logic [2:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  return SEL_ADD;
      OP_AND:  return SEL_AND;
      OP_NEG:  return SEL_NEG;
      OP_TSTN: return SEL_TSTN;
      OP_TSTZ: return SEL_TSTZ;
      OP_SUB:  return SEL_ADD;
      default: return SEL_IDLE;
    endcase
  endfunction

  function automatic logic op_writes_rf(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NEG) || (op == OP_SUB);
  endfunction

  function automatic logic op_sets_c(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_sets_z(input logic [2:0] op);
    return (op == OP_TSTN) || (op == OP_TSTZ);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
// NREGS x DATA_W register file for the ALU issue sequencer.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset (clears all)
//   we_i, wa_i, wd_i        synchronous write port
//   ra_a_i / rd_a_o         asynchronous read port A
//   ra_b_i / rd_b_o         asynchronous read port B
//   dbg_addr_i / dbg_data_o asynchronous debug read port
// -----------------------------------------------------------------------------
module alu_seq_regfile #(
  parameter int DATA_W = 12,
  parameter int NREGS  = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [RA_W-1:0]   ra_a_i,
  output logic [DATA_W-1:0] rd_a_o,
  input  logic [RA_W-1:0]   ra_b_i,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic [RA_W-1:0]   dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // NOTE: resetting every entry keeps this array in flops rather than a RAM
  // macro; that is intended, as software expects all registers to read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o     = mem_q[ra_a_i];
  assign rd_b_o     = mem_q[ra_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_seq.sv
// -----------------------------------------------------------------------------
// alu_issue_seq
// Multicycle issue sequencer sitting in front of a DATA_W-bit ALU. Accepts one
// register-register op per valid/ready handshake, reads its operands from an
// internal register file, drives the ALU inputs, captures the ALU outputs,
// writes back and maintains the Z/C flags.
//
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE (SUB: READ -> NEG_B -> EXEC).
//
// Configuration macro: ALU_SUB_EN (enables opcode 101 = SUB ra-rb).
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   op_valid_i / op_ready_o     instruction handshake (ready only in IDLE)
//   op_i, rd_i, ra_i, rb_i      opcode, destination and source registers
//   alu_a_o, alu_b_o, alu_sel_o registered ALU operand/select drive
//   alu_o_i, alu_cy_i, alu_zero_i  ALU result, carry, zero
//   done_o                      1-cycle pulse in the write-back cycle
//   err_o                       1-cycle pulse after an illegal op is dropped
//   flag_z_o, flag_c_o          status flags
//   clr_flags_i                 clears both flags (a same-cycle update wins)
//   dbg_addr_i / dbg_data_o     combinational register-file read
// -----------------------------------------------------------------------------
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREGS  = SEQ_NREGS,
  parameter int RA_W   = SEQ_RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic [RA_W-1:0]   ra_i,
  input  logic [RA_W-1:0]   rb_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_sel_o,
  input  logic [DATA_W-1:0] alu_o_i,
  input  logic              alu_cy_i,
  input  logic              alu_zero_i,
  output logic              done_o,
  output logic              err_o,
  output logic              flag_z_o,
  output logic              flag_c_o,
  input  logic              clr_flags_i,
  input  logic [RA_W-1:0]   dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [RA_W-1:0]   ra_q, ra_d;
  logic [RA_W-1:0]   rb_q, rb_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cy_q, cy_d;
  logic              z_q, z_d;
  logic              err_q, err_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_a, rf_b;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .wa_i       (rd_q),
    .wd_i       (res_q),
    .ra_a_i     (ra_q),
    .rd_a_o     (rf_a),
    .ra_b_i     (rb_q),
    .rd_b_o     (rf_b),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // NOTE: every variable gets its hold value first so that no path through
  // the case statement leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    res_d     = res_q;
    cy_d      = cy_q;
    z_d       = z_q;
    err_d     = 1'b0;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    rf_we     = 1'b0;

    // Clear first; a write-back flag update later in this block overrides it.
    if (clr_flags_i) begin
      flag_z_d = 1'b0;
      flag_c_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        alu_sel_d = SEL_IDLE;
        if (op_valid_i) begin
          if (op_legal(op_i)) begin
            op_d    = op_i;
            rd_d    = rd_i;
            ra_d    = ra_i;
            rb_d    = rb_i;
            state_d = ST_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_READ: begin
`ifdef ALU_SUB_EN
        if (op_q == OP_SUB) begin
          // First pass: let the ALU negate rb.
          alu_a_d   = rf_b;
          alu_sel_d = SEL_NEG;
          state_d   = ST_NEG_B;
        end else
`endif
        begin
          alu_a_d   = rf_a;
          alu_b_d   = rf_b;
          alu_sel_d = op_to_sel(op_q);
          state_d   = ST_EXEC;
        end
      end

`ifdef ALU_SUB_EN
      ST_NEG_B: begin
        // The negated rb goes straight into the B operand register, which
        // doubles as the temporary for the second (ADD) pass.
        alu_a_d   = rf_a;
        alu_b_d   = alu_o_i;
        alu_sel_d = SEL_ADD;
        state_d   = ST_EXEC;
      end
`endif

      ST_EXEC: begin
        res_d   = alu_o_i;
        cy_d    = alu_cy_i;
        z_d     = alu_zero_i;
        state_d = ST_WB;
      end

      ST_WB: begin
        rf_we     = op_writes_rf(op_q);
        alu_sel_d = SEL_IDLE;
        if (op_sets_c(op_q)) flag_c_d = cy_q;
        if (op_sets_z(op_q)) flag_z_d = z_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= SEL_IDLE;
      res_q     <= '0;
      cy_q      <= 1'b0;
      z_q       <= 1'b0;
      err_q     <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      res_q     <= res_d;
      cy_q      <= cy_d;
      z_q       <= z_d;
      err_q     <= err_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  assign op_ready_o = (state_q == ST_IDLE);
  assign done_o     = (state_q == ST_WB);
  assign err_o      = err_q;
  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_sel_o  = alu_sel_q;
  assign flag_z_o   = flag_z_q;
  assign flag_c_o   = flag_c_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_seq
// Self-checking bench for alu_issue_seq. Provides a behavioural 12-bit ALU
// (with an override used to preload registers through ordinary write-back)
// and an architectural reference model of registers and flags.
// -----------------------------------------------------------------------------
module tb_alu_issue_seq;

  localparam int W = 12;
  localparam int N = 8;
`ifdef ALU_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid_i;
  logic         op_ready_o;
  logic [2:0]   op_i;
  logic [2:0]   rd_i, ra_i, rb_i;
  logic [W-1:0] alu_a_o, alu_b_o;
  logic [2:0]   alu_sel_o;
  logic [W-1:0] alu_o_i;
  logic         alu_cy_i, alu_zero_i;
  logic         done_o, err_o, flag_z_o, flag_c_o;
  logic         clr_flags_i;
  logic [2:0]   dbg_addr_i;
  logic [W-1:0] dbg_data_o;

  always #10 clk = ~clk;

  alu_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_i        (op_i),
    .rd_i        (rd_i),
    .ra_i        (ra_i),
    .rb_i        (rb_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_sel_o   (alu_sel_o),
    .alu_o_i     (alu_o_i),
    .alu_cy_i    (alu_cy_i),
    .alu_zero_i  (alu_zero_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .flag_z_o    (flag_z_o),
    .flag_c_o    (flag_c_o),
    .clr_flags_i (clr_flags_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_data_o  (dbg_data_o)
  );

  // Behavioural ALU. TSTN reports "zero" when A is negative, TSTZ when A is 0.
  logic         ovr_en;
  logic [W-1:0] ovr_val;
  always_comb begin
    alu_o_i    = '0;
    alu_cy_i   = 1'b0;
    alu_zero_i = 1'b0;
    if (ovr_en) begin
      alu_o_i = ovr_val;
    end else begin
      case (alu_sel_o)
        3'd0: {alu_cy_i, alu_o_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        3'd1: alu_o_i = alu_a_o & alu_b_o;
        3'd4: alu_o_i = -alu_a_o;
        3'd5: alu_zero_i = alu_a_o[W-1];
        3'd6: alu_zero_i = (alu_a_o == '0);
        default: ;
      endcase
    end
  end

  // Architectural reference model
  int rf_m [N];
  bit fz_m, fc_m;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < N; i++) begin
      dbg_addr_i = 3'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(dbg_data_o), 32'(rf_m[i]));
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_z"}, 32'(flag_z_o), 32'(fz_m));
    check({tag, "_c"}, 32'(flag_c_o), 32'(fc_m));
  endtask

  // Apply an op to the model from the architectural rules.
  task automatic model_apply(input int op, input int rd, input int ra, input int rb);
    int a, b, s;
    a = rf_m[ra];
    b = rf_m[rb];
    case (op)
      0: begin s = a + b; rf_m[rd] = s % 4096; fc_m = (s >= 4096); end
      1: rf_m[rd] = a & b;
      2: rf_m[rd] = (4096 - a) % 4096;
      3: fz_m = (a >= 2048);
      4: fz_m = (a == 0);
      5: begin s = a + ((4096 - b) % 4096); rf_m[rd] = s % 4096; fc_m = (s >= 4096); end
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion, update the model and compare.
  task automatic run_op(input int op, input int rd, input int ra, input int rb);
    bit legal;
    int n, exp_lat;
    legal   = (op <= 4) || (SUB_EN && op == 5);
    exp_lat = (op == 5) ? 4 : 3;
    check("ready_before_issue", 32'(op_ready_o), 32'd1);
    op_valid_i = 1'b1;
    op_i = 3'(op); rd_i = 3'(rd); ra_i = 3'(ra); rb_i = 3'(rb);
    tick();
    op_valid_i = 1'b0;
    if (!legal) begin
      check("err_pulse", 32'(err_o), 32'd1);
      check("ready_on_err", 32'(op_ready_o), 32'd1);
      tick();
      check("err_clear", 32'(err_o), 32'd0);
      check("done_on_err", 32'(done_o), 32'd0);
    end else begin
      n = 1;
      check("ready_low_busy", 32'(op_ready_o), 32'd0);
      while (!done_o && n < 10) begin
        tick();
        n++;
      end
      check("latency", 32'(n), 32'(exp_lat));
      tick();
      if (ovr_en) begin
        rf_m[rd] = int'(ovr_val);
        fc_m = 1'b0;
      end else begin
        model_apply(op, rd, ra, rb);
      end
      check("done_clear", 32'(done_o), 32'd0);
      check("ready_back", 32'(op_ready_o), 32'd1);
      check("alu_sel_idle", 32'(alu_sel_o), 32'd7);
    end
    check_flags("flags");
  endtask

  // Preload a register by forcing the ALU result under an ADD.
  task automatic load(input int rd, input int val);
    ovr_en  = 1'b1;
    ovr_val = W'(val);
    run_op(0, rd, 0, 0);
    ovr_en  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags_i = 1'b1;
    tick();
    clr_flags_i = 1'b0;
    fz_m = 1'b0;
    fc_m = 1'b0;
    check_flags("clr");
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) rf_m[i] = 0;
    fz_m = 1'b0;
    fc_m = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op_valid_i = 1'b0; op_i = '0; rd_i = '0; ra_i = '0; rb_i = '0;
    clr_flags_i = 1'b0; dbg_addr_i = '0; ovr_en = 1'b0; ovr_val = '0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_ready", 32'(op_ready_o), 32'd1);
    check("rst_sel", 32'(alu_sel_o), 32'd7);
    check("rst_a", 32'(alu_a_o), 32'd0);
    check("rst_b", 32'(alu_b_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check_flags("rst");
    check_rf("rst");

    // ADD without carry
    load(1, 'h7FF);
    load(2, 'h001);
    run_op(0, 3, 1, 2);
    dbg_addr_i = 3'd3; #1;
    check("add_r3", 32'(dbg_data_o), 32'h800);
    check("add_c0", 32'(flag_c_o), 32'd0);

    // ADD with carry out, then AND leaves C alone
    load(1, 'hFFF);
    run_op(0, 4, 1, 2);
    dbg_addr_i = 3'd4; #1;
    check("add_r4", 32'(dbg_data_o), 32'h000);
    check("add_c1", 32'(flag_c_o), 32'd1);
    run_op(1, 6, 1, 2);
    dbg_addr_i = 3'd6; #1;
    check("and_r6", 32'(dbg_data_o), 32'h001);
    check("and_c_kept", 32'(flag_c_o), 32'd1);

    // TSTN sets Z, writes nothing; clear drops it next cycle
    load(5, 'h800);
    run_op(3, 0, 5, 0);
    check("tstn_z", 32'(flag_z_o), 32'd1);
    check_rf("tstn");
    pulse_clr();

    // Clear held through an op: write-back update wins over the clear
    run_op(0, 7, 1, 1);
    clr_flags_i = 1'b1;
    fz_m = 1'b0; fc_m = 1'b0;
    run_op(4, 0, 4, 0);
    clr_flags_i = 1'b0;
    check("clr_vs_upd_z", 32'(flag_z_o), 32'd1);
    check("clr_vs_upd_c", 32'(flag_c_o), 32'd0);
    tick();

    // Illegal opcodes (and 101 when SUB is disabled)
    run_op(7, 2, 1, 1);
    run_op(6, 2, 1, 1);
    check_rf("illegal");
    if (SUB_EN) begin
      load(1, 'h005);
      load(2, 'h003);
      run_op(5, 1, 1, 2);
      dbg_addr_i = 3'd1; #1;
      check("sub_r1", 32'(dbg_data_o), 32'h002);
    end else begin
      run_op(5, 1, 1, 2);
    end
    check_rf("post_sub");

    // Randomized ops against the model
    for (int it = 0; it < 60; it++) begin
      if (it % 4 == 0) load(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 7) == 0) pulse_clr();
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if (it % 10 == 9) check_rf("rand");
    end
    check_rf("rand_end");

    // Reset while in EXEC: op discarded, everything back to reset values
    load(3, 'h123);
    op_valid_i = 1'b1; op_i = 3'd0; rd_i = 3'd3; ra_i = 3'd3; rb_i = 3'd3;
    tick();
    op_valid_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("midrst_ready", 32'(op_ready_o), 32'd1);
    check("midrst_sel", 32'(alu_sel_o), 32'd7);
    check("midrst_done", 32'(done_o), 32'd0);
    check_flags("midrst");
    check_rf("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 32'(done_o), 32'd0);
    end
    check_rf("midrst_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
